// File: rtl/serializer_arbiter.sv
// -----------------------------------------------------------------------------
// serializer_arbiter
//
// Purpose:
//   Shares one byte-wide serial sink between two 32-bit word producers. One
//   producer is granted at a time (round-robin or fixed priority). The granted
//   word is latched and acknowledged, then its bytes are emitted LSB first on
//   the out_data / out_data_available strobe protocol. Bytes of different words
//   are never interleaved.
//
// Parameters:
//   ROUND_ROBIN  1 = alternate grant on contention, 0 = requester 0 always wins
//   MAX_BYTES    bytes per word (at most 4); larger counts are clamped to it
//
// Ports:
//   clk                 in   1   clock, all state on posedge
//   reset               in   1   asynchronous, active-high reset
//   in_data_0           in   32  requester 0 word, byte 0 = bits [7:0]
//   in_data_count_0     in   3   requester 0 byte count, 0 = no request
//   in_ack_0            out  1   one-cycle pulse: requester 0 word latched
//   in_data_1           in   32  requester 1 word
//   in_data_count_1     in   3   requester 1 byte count, 0 = no request
//   in_ack_1            out  1   one-cycle pulse: requester 1 word latched
//   receiver_ready      in   1   sink can accept a byte this cycle
//   out_data            out  8   byte to sink, valid while out_data_available
//   out_data_available  out  1   one-cycle strobe per byte
//   out_source          out  1   requester owning the current/last word
//   busy                out  1   high while the FSM is not idle
// -----------------------------------------------------------------------------
module serializer_arbiter #(
    parameter int ROUND_ROBIN = 1,
    parameter int MAX_BYTES   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data_0,
    input  logic [2:0]  in_data_count_0,
    output logic        in_ack_0,
    input  logic [31:0] in_data_1,
    input  logic [2:0]  in_data_count_1,
    output logic        in_ack_1,
    input  logic        receiver_ready,
    output logic [7:0]  out_data,
    output logic        out_data_available,
    output logic        out_source,
    output logic        busy
);

    // One extra bit so that idx can reach MAX_BYTES and compare against count.
    localparam int IDX_W = $clog2(MAX_BYTES) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t                       state;
    logic [MAX_BYTES-1:0][7:0]    word_bytes;
    logic [IDX_W-1:0]             count;
    logic [IDX_W-1:0]             idx;
    logic                         last_grant;

    logic                         req_0;
    logic                         req_1;
    logic                         winner;
    logic [31:0]                  sel_data;
    logic [2:0]                   sel_count;

    // Counts above MAX_BYTES would walk past the latched word, so clamp them.
    function automatic logic [IDX_W-1:0] clamp_count(input logic [2:0] c);
        if (int'(c) > MAX_BYTES)
            return IDX_W'(MAX_BYTES);
        else
            return IDX_W'(c);
    endfunction

    // Grant decision. A lone requester always wins; on a tie the round-robin
    // variant hands the grant to whoever did not get it last time.
    always_comb begin
        req_0  = (in_data_count_0 != 3'd0);
        req_1  = (in_data_count_1 != 3'd0);
        winner = 1'b0;
        if (req_0 && req_1)
            winner = (ROUND_ROBIN != 0) ? ~last_grant : 1'b0;
        else if (req_1)
            winner = 1'b1;
        sel_data  = winner ? in_data_1 : in_data_0;
        sel_count = winner ? in_data_count_1 : in_data_count_0;
    end

    // Main FSM. SEND emits one byte and GAP always follows it, which keeps the
    // strobe from ever being high on two consecutive cycles. Requests are only
    // looked at in IDLE, so a stalled word keeps ownership of the sink.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            word_bytes         <= '0;
            count              <= '0;
            idx                <= '0;
            last_grant         <= 1'b1;
            out_data           <= 8'd0;
            out_data_available <= 1'b0;
            in_ack_0           <= 1'b0;
            in_ack_1           <= 1'b0;
            out_source         <= 1'b0;
            busy               <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ack_0           <= 1'b0;
                    in_ack_1           <= 1'b0;
                    out_data_available <= 1'b0;
                    if (req_0 || req_1) begin
                        word_bytes <= sel_data[8*MAX_BYTES-1:0];
                        count      <= clamp_count(sel_count);
                        idx        <= '0;
                        last_grant <= winner;
                        out_source <= winner;
                        in_ack_0   <= ~winner;
                        in_ack_1   <= winner;
                        state      <= SEND;
                        busy       <= 1'b1;
                    end
                end
                SEND: begin
                    in_ack_0 <= 1'b0;
                    in_ack_1 <= 1'b0;
                    if (receiver_ready) begin
                        out_data           <= word_bytes[idx[IDX_W-2:0]];
                        out_data_available <= 1'b1;
                        idx                <= idx + IDX_W'(1);
                        state              <= GAP;
                    end else begin
                        out_data_available <= 1'b0;
                    end
                end
                GAP: begin
                    out_data_available <= 1'b0;
                    if (idx == count) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= SEND;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
